// File: rtl/mem_stage_bus_if.sv
// mem_stage_bus_if: data-memory bus between the EX/MEM register (master)
// and the MEM stage decoder (slave).
//   mem_addr  : byte address (ALU result), word access only
//   mem_wdata : store data
//   mem_read  : load strobe
//   mem_write : store strobe
//   mem_rdata : combinational load data returned by the slave
interface mem_stage_bus_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_stage_bus.sv
// mem_stage_bus: MEM stage of the 5-stage pipeline. Decodes the EX/MEM
// address onto data RAM or the peripheral window (timer TH/TL/TCON, LEDs,
// 7-seg digits, systick) and returns load data combinationally.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_stage_bus_if slave (mem_addr/mem_wdata/mem_read/mem_write in,
//           mem_rdata out)
//   irq   : timer interrupt request, equal to TCON[2]
//   led   : LED register
//   digi  : 7-seg register (anodes + segments)
module mem_stage_bus #(
  parameter int unsigned RAM_WORDS   = 256,
  parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_stage_bus_if.slave        bus,
  output logic                  irq,
  output logic [7:0]            led,
  output logic [11:0]           digi
);

  localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
  localparam logic [31:0] PBASE_W   = PERIPH_BASE >> 2;

  typedef enum logic [2:0] {
    R_TH      = 3'd0,
    R_TL      = 3'd1,
    R_TCON    = 3'd2,
    R_LED     = 3'd3,
    R_DIGI    = 3'd4,
    R_SYSTICK = 3'd5,
    R_NONE    = 3'd7
  } reg_sel_e;

  logic [31:0] ram [RAM_WORDS];

  logic [31:0] th, tl, systick;
  logic [2:0]  tcon;

  logic [31:0] word_addr;
  logic [31:0] off_w;
  logic [AW-1:0] ram_idx;
  logic        ram_hit;
  reg_sel_e    sel;

  // Word-granular decode: the two byte-offset bits drop out of the shift.
  assign word_addr = bus.mem_addr >> 2;
  assign off_w     = word_addr - PBASE_W;
  assign ram_hit   = (bus.mem_addr < RAM_BYTES);
  assign ram_idx   = word_addr[AW-1:0];

  always_comb begin
    sel = R_NONE;
    if (!ram_hit && off_w[31:3] == '0) begin
      case (off_w[2:0])
        3'd0:    sel = R_TH;
        3'd1:    sel = R_TL;
        3'd2:    sel = R_TCON;
        3'd3:    sel = R_LED;
        3'd4:    sel = R_DIGI;
        3'd5:    sel = R_SYSTICK;
        default: sel = R_NONE;
      endcase
    end
  end

  // Load data reflects pre-edge state, so a simultaneous store is not visible
  // until the following cycle.
  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_read) begin
      if (ram_hit) begin
        bus.mem_rdata = ram[ram_idx];
      end else begin
        case (sel)
          R_TH:      bus.mem_rdata = th;
          R_TL:      bus.mem_rdata = tl;
          R_TCON:    bus.mem_rdata = {29'd0, tcon};
          R_LED:     bus.mem_rdata = {24'd0, led};
          R_DIGI:    bus.mem_rdata = {20'd0, digi};
          R_SYSTICK: bus.mem_rdata = systick;
          default:   bus.mem_rdata = '0;
        endcase
      end
    end
  end

  // RAM has no reset; contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (bus.mem_write && ram_hit) begin
      ram[ram_idx] <= bus.mem_wdata;
    end
  end

  // Timer/counter updates are issued first and software writes afterwards, so
  // a store in the same cycle overrides the hardware update (last NBA wins).
  // The reload reads th before any same-cycle TH store lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (tcon[0]) begin
        if (tl != '1) begin
          tl <= tl + 32'd1;
        end else begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end
      end

      if (bus.mem_write) begin
        case (sel)
          R_TH:    th   <= bus.mem_wdata;
          R_TL:    tl   <= bus.mem_wdata;
          R_TCON:  tcon <= bus.mem_wdata[2:0];
          R_LED:   led  <= bus.mem_wdata[7:0];
          R_DIGI:  digi <= bus.mem_wdata[11:0];
          default: ;
        endcase
      end
    end
  end

  assign irq = tcon[2];

endmodule

// File: tb/tb_mem_stage_bus.sv
module tb_mem_stage_bus;

  localparam logic [31:0] PB     = 32'h4000_0000;
  localparam logic [31:0] A_TH   = PB + 32'h00;
  localparam logic [31:0] A_TL   = PB + 32'h04;
  localparam logic [31:0] A_TCON = PB + 32'h08;
  localparam logic [31:0] A_LED  = PB + 32'h0C;
  localparam logic [31:0] A_DIGI = PB + 32'h10;
  localparam logic [31:0] A_SYS  = PB + 32'h14;
  localparam logic [31:0] A_UNM  = PB + 32'h18;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;

  int checks = 0;
  int failures = 0;

  mem_stage_bus_if bus();

  mem_stage_bus #(
    .RAM_WORDS(256),
    .PERIPH_BASE(32'h4000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave),
    .irq  (irq),
    .led  (led),
    .digi (digi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    tick();
    bus.mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.mem_addr = a;
    bus.mem_read = 1'b1;
    #1;
    v = bus.mem_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] addrs [6];
    addrs = '{A_TH, A_TL, A_TCON, A_LED, A_DIGI, A_SYS};
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v);
      checks++;
      if (v !== 32'd0) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, v, 32'd0);
      end
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++;
    if (led !== 8'd0 || digi !== 12'd0) begin
      failures++; $display("FAIL reset_ports got=%h/%h exp=00/000", led, digi);
    end
  endtask

  task automatic test_ram();
    logic [31:0] v;
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd got=%h exp=deadbeef", v); end
    rd(32'h13, v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rd_unaligned got=%h exp=deadbeef", v); end
    bus.mem_read = 1'b0;
    #1;
    checks++;
    if (bus.mem_rdata !== 32'd0) begin failures++; $display("FAIL ram_noread got=%h exp=0", bus.mem_rdata); end
    // simultaneous read and write: pre-write value this cycle, new value next
    bus.mem_addr  = 32'h10;
    bus.mem_wdata = 32'h1234_5678;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    #1;
    checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_rw_old got=%h exp=deadbeef", bus.mem_rdata); end
    tick();
    bus.mem_write = 1'b0;
    #1;
    checks++;
    if (bus.mem_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ram_rw_new got=%h exp=12345678", bus.mem_rdata); end
    wr(32'h3FC, 32'hCAFE_F00D);
    rd(32'h3FC, v);
    checks++;
    if (v !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_last got=%h exp=cafef00d", v); end
    wr(32'h400, 32'h5555_5555);
    rd(32'h400, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL ram_beyond got=%h exp=0", v); end
  endtask

  task automatic test_periph();
    logic [31:0] v;
    wr(A_LED, 32'h1FF);
    checks++;
    if (led !== 8'hFF) begin failures++; $display("FAIL led_port got=%h exp=ff", led); end
    rd(A_LED, v);
    checks++;
    if (v !== 32'h0000_00FF) begin failures++; $display("FAIL led_rd got=%h exp=000000ff", v); end
    wr(A_DIGI, 32'hABCD);
    checks++;
    if (digi !== 12'hBCD) begin failures++; $display("FAIL digi_port got=%h exp=bcd", digi); end
    rd(A_DIGI, v);
    checks++;
    if (v !== 32'h0000_0BCD) begin failures++; $display("FAIL digi_rd got=%h exp=00000bcd", v); end
    wr(A_TCON, 32'hFFFF_FFF8);
    rd(A_TCON, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL tcon_mask got=%h exp=0", v); end
    wr(A_UNM, 32'hFFFF_FFFF);
    wr(A_SYS, 32'h0);
    checks++;
    if (led !== 8'hFF || digi !== 12'hBCD) begin
      failures++; $display("FAIL unmapped_ports got=%h/%h exp=ff/bcd", led, digi);
    end
    rd(A_TH, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL unmapped_th got=%h exp=0", v); end
    rd(A_TL, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL unmapped_tl got=%h exp=0", v); end
    rd(A_UNM, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", v); end
    rd(PB + 32'h1C, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL unmapped_rd1c got=%h exp=0", v); end
  endtask

  task automatic test_systick();
    logic [31:0] a, b, c;
    rd(A_SYS, a);
    tick();
    rd(A_SYS, b);
    checks++;
    if (b !== a + 32'd1) begin failures++; $display("FAIL systick_step got=%h exp=%h", b, a + 32'd1); end
    tick();
    tick();
    rd(A_SYS, c);
    checks++;
    if (c !== b + 32'd2) begin failures++; $display("FAIL systick_step2 got=%h exp=%h", c, b + 32'd2); end
    force dut.systick = 32'hFFFF_FFFF;
    rd(A_SYS, a);
    checks++;
    if (a !== 32'hFFFF_FFFF) begin failures++; $display("FAIL systick_forced got=%h exp=ffffffff", a); end
    release dut.systick;
    tick();
    rd(A_SYS, b);
    checks++;
    if (b !== 32'd0) begin failures++; $display("FAIL systick_wrap got=%h exp=0", b); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    logic [31:0] exp_tl [5];
    logic        exp_irq [5];
    exp_tl  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    exp_irq = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    wr(A_TH, 32'hFFFF_FFFD);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h3);
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFE) begin failures++; $display("FAIL timer_start got=%h exp=fffffffe", v); end
    for (int i = 0; i < 5; i++) begin
      tick();
      rd(A_TL, v);
      checks++;
      if (v !== exp_tl[i]) begin failures++; $display("FAIL timer_tl%0d got=%h exp=%h", i, v, exp_tl[i]); end
      checks++;
      if (irq !== exp_irq[i]) begin failures++; $display("FAIL timer_irq%0d got=%b exp=%b", i, irq, exp_irq[i]); end
    end
    rd(A_TCON, v);
    checks++;
    if (v !== 32'h7) begin failures++; $display("FAIL timer_tcon got=%h exp=7", v); end
  endtask

  task automatic test_isr_race();
    logic [31:0] v;
    tick();
    tick();
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL race_pre_tl got=%h exp=ffffffff", v); end
    wr(A_TCON, 32'h3);
    rd(A_TCON, v);
    checks++;
    if (v !== 32'h3) begin failures++; $display("FAIL race_tcon got=%h exp=3", v); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL race_irq_clr got=%b exp=0", irq); end
    rd(A_TL, v);
    checks++;
    if (v !== 32'hFFFF_FFFD) begin failures++; $display("FAIL race_reload got=%h exp=fffffffd", v); end
    tick();
    tick();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL race_irq_hold got=%b exp=0", irq); end
    tick();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL race_irq_again got=%b exp=1", irq); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [31:0] addrs [6];
    addrs = '{A_TH, A_TL, A_TCON, A_LED, A_DIGI, A_SYS};
    wr(A_DIGI, 32'h123);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL rstmid_pre_irq got=%b exp=1", irq); end
    bus.mem_addr  = A_LED;
    bus.mem_wdata = 32'h55;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.mem_write = 1'b0;
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
    checks++;
    if (led !== 8'd0 || digi !== 12'd0) begin
      failures++; $display("FAIL rstmid_ports got=%h/%h exp=00/000", led, digi);
    end
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL rstmid_reg%0d got=%h exp=0", i, v); end
    end
    tick();
    rd(A_TL, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL rstmid_stopped got=%h exp=0", v); end
  endtask

  initial begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    test_reset();
    test_ram();
    test_periph();
    test_systick();
    test_timer();
    test_isr_race();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage_bus.md
Name: mem_stage_bus

Overview:
- MEM stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Takes the latched ALU result as a byte address, the store data, and the read/write strobes. Decodes them onto data RAM or memory-mapped peripherals: timer, LEDs, 7-seg digits, systick.
- Returns load data combinationally so MEM/WB captures it in the same cycle.
- Raises the timer interrupt request consumed by the exception/PC logic.

Parameters:
- RAM_WORDS, 256, number of 32-bit data RAM words; RAM occupies byte addresses 0x00000000 .. 4*RAM_WORDS-1.
- PERIPH_BASE, 32'h40000000, base byte address of the peripheral window.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- mem_addr  in  32  byte address (EX/MEM ALU result)
- mem_wdata  in  32  store data (EX/MEM rt data)
- mem_read  in  1  load strobe
- mem_write  in  1  store strobe
- mem_rdata  out  32  load data, combinational
- irq  out  1  timer interrupt request (= TCON[2])
- led  out  8  LED register
- digi  out  12  7-seg register (anodes + segments)

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. Reset values: TH=0, TL=0, TCON=3'b000, led=0, digi=0, systick=0, irq=0. RAM contents are not cleared by reset.
- Addressing: mem_addr[1:0] ignored (word access only).
- RAM hit: mem_addr < 4*RAM_WORDS.
- Peripheral map, offsets from PERIPH_BASE:
  - 0x00 TH (rw, 32)
  - 0x04 TL (rw, 32)
  - 0x08 TCON (rw, bits[2:0])
  - 0x0C led (rw, bits[7:0])
  - 0x10 digi (rw, bits[11:0])
  - 0x14 systick (read-only)
- Any other address is unmapped.
- Reads (combinational, zero latency):
  - mem_read=0 -> mem_rdata=0.
  - RAM hit -> word at mem_addr[31:2].
  - Peripheral -> register value zero-extended to 32 bits.
  - Unmapped -> 0.
- Writes: take effect at the rising edge when mem_write=1.
  - RAM hit -> word written.
  - TH/TL -> full 32 bits.
  - TCON <- wdata[2:0]; led <- wdata[7:0]; digi <- wdata[11:0].
  - Writes to systick or unmapped addresses are ignored with no side effects.
- mem_read and mem_write both high: the write is performed at the edge; mem_rdata shows the pre-write value during that cycle.
- Read-after-write, next cycle: returns the new value.
- TCON bits: [0] enable, [1] interrupt enable, [2] interrupt status.
- Timer update each cycle with TCON[0]=1:
  - TL != 32'hFFFFFFFF -> TL <= TL+1.
  - TL == 32'hFFFFFFFF -> TL <= TH, and if TCON[1]=1, TCON[2] <= 1.
- Timer with TCON[0]=0: TL holds.
- TCON[2] is sticky. It clears only by a software write of TCON or by reset.
- irq is registered: irq = TCON[2], so it asserts the cycle after the overflow edge.
- systick: increments every cycle, independent of TCON. Wraps 0xFFFFFFFF -> 0.
- Simultaneous events:
  - Software write to TL in the same cycle as increment/reload -> software value wins.
  - Software write to TCON in the same cycle as an overflow setting TCON[2] -> software value wins. This lets the ISR's clear never be lost to a racing overflow; the next overflow sets it again.
  - Software write to TH in the same cycle as a reload -> TL reloads the old TH; the new TH takes effect from the next reload.
- Reset mid-count: the reset edge forces all registers to their reset values regardless of mem_write; timer stopped, irq low the following cycle.

Test Plan:
- RAM path: write 0xDEADBEEF to 0x00000010 -> next cycle, read 0x00000010 gives 0xDEADBEEF. Read 0x00000013 gives the same word. With mem_read=0, mem_rdata=0.
- Timer reload + irq: TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3'b011.
  - TL sequence: 0xFFFFFFFF, 0xFFFFFFFD, 0xFFFFFFFE, 0xFFFFFFFF, 0xFFFFFFFD.
  - TCON[2]/irq go high one cycle after the first reload and stay high.
- ISR race: with irq pending, write TCON=3'b011 in the exact cycle TL wraps -> TCON reads 3'b011 and irq low next cycle. The next wrap re-asserts irq.
- Peripheral registers / unmapped: write 0x1FF to led and 0xABCD to digi -> led=0xFF, digi=0xBCD. Write to 0x40000018 and to systick -> no register changes. Read 0x40000018 gives 0.
- systick: after reset deassert, reads on consecutive cycles differ by exactly 1. Forced value 0xFFFFFFFF wraps to 0.
- Reset mid-operation: timer running with irq=1, assert reset for one cycle while mem_write=1 to led -> TH/TL/TCON/led/digi/systick all 0, irq=0, the led write is discarded.
